// File: rtl/arith_chain_ctrl.sv
// Sequenced multiply/add/subtract chain: f = (X*Y + d - Y) mod 2^W.
// All arithmetic goes through one shared (2W+1)-bit adder/subtractor.
module arith_chain_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  input  logic [WIDTH-1:0]   d,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   c,
  output logic [2*WIDTH-1:0] c_full,
  output logic [WIDTH-1:0]   e,
  output logic [WIDTH-1:0]   f,
  output logic               c_ovf,
  output logic               e_carry,
  output logic               f_borrow
);
  localparam int W  = WIDTH;
  localparam int AW = 2 * W + 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, MUL, ADD, SUB, DONE} state_t;

  state_t        state, nextState;
  logic [W-1:0]  xReg, yReg, dReg;
  logic [2*W-1:0] acc;
  logic [CW-1:0] bitCnt;

  logic [AW-1:0] opA, opB, sum;
  logic          subSel;

  // Operand selection for the shared adder; subtraction is a + ~b + 1.
  always_comb begin
    opA    = '0;
    opB    = '0;
    subSel = 1'b0;
    case (state)
      MUL: begin
        opA = AW'(acc);
        opB = yReg[bitCnt] ? (AW'(xReg) << bitCnt) : '0;
      end
      ADD: begin
        opA = AW'(acc[W-1:0]);
        opB = AW'(dReg);
      end
      SUB: begin
        opA    = AW'(e);
        opB    = AW'(yReg);
        subSel = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum = opA + (subSel ? ~opB : opB) + AW'(subSel);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = MUL;
      MUL:     if (bitCnt == CW'(W - 1)) nextState = ADD;
      ADD:     nextState = SUB;
      SUB:     nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      xReg     <= '0;
      yReg     <= '0;
      dReg     <= '0;
      acc      <= '0;
      bitCnt   <= '0;
      c        <= '0;
      c_full   <= '0;
      e        <= '0;
      f        <= '0;
      c_ovf    <= 1'b0;
      e_carry  <= 1'b0;
      f_borrow <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: if (start) begin
          xReg   <= X;
          yReg   <= Y;
          dReg   <= d;
          acc    <= '0;
          bitCnt <= '0;
        end
        MUL: begin
          acc    <= sum[2*W-1:0];
          bitCnt <= bitCnt + CW'(1);
        end
        ADD: begin
          c_full  <= acc;
          c       <= acc[W-1:0];
          c_ovf   <= |acc[2*W-1:W];
          e       <= sum[W-1:0];
          e_carry <= sum[W];
        end
        SUB: begin
          f        <= sum[W-1:0];
          // Zero-extended operands: the top bit is set only when e < Y.
          f_borrow <= sum[AW-1];
        end
        default: ;
      endcase
    end
  end
endmodule
